// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART receive byte port: receiver
//            state encoding, frame width and the baud-divider rounding helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int BITS_PER_FRAME = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest: round(clk_hz / (baud * oversample)).
  function automatic int calc_div(input longint clk_hz, input longint baud, input longint oversample);
    longint den;
    den = baud * oversample;
    return int'((clk_hz + den / 2) / den);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Small synchronous FIFO for received bytes. A pop on an empty
//            FIFO is ignored; a push on a full FIFO is accepted only when a
//            pop frees a slot in the same clock, otherwise it is dropped.
// Ports    : clk, reset_n     - clock, asynchronous active-low reset
//            push, push_data  - write request and data
//            pop              - advance head
//            head             - current head entry, zero when empty
//            empty, full      - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the same clock pops the head.
  assign w_push_ok = push && (!full || w_pop_ok);
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte_port.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte_port
// Purpose  : 8N1 serial receiver feeding a polled parallel input port.
//            Oversamples rxd, assembles LSB-first bytes, buffers them in a
//            FIFO and reports sticky framing / overrun errors.
// Ports    : clk, reset_n  - clock, asynchronous active-low reset
//            rxd           - asynchronous serial line, idle high
//            rd_ack        - level; each rising edge pops one byte
//            err_clr       - level; each rising edge clears both error flags
//            data_out      - FIFO head byte, zero when empty
//            data_valid    - FIFO not empty
//            framing_err   - sticky, stop bit sampled low
//            overrun       - sticky, byte dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte_port
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       rd_ack,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_err,
  output logic       overrun
);

  localparam int DIV = calc_div(longint'(CLK_HZ), longint'(BAUD), longint'(OVERSAMPLE));
  localparam int DW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(BITS_PER_FRAME);

  // Synchronizers and edge detectors.
  logic r_rx_s1, r_rx_s2;
  logic r_ack_s1, r_ack_s2, r_ack_d;
  logic r_clr_s1, r_clr_s2, r_clr_d;
  logic w_ack_rise, w_clr_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_ack_d  <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
      r_clr_d  <= 1'b0;
    end else begin
      r_rx_s1  <= rxd;
      r_rx_s2  <= r_rx_s1;
      r_ack_s1 <= rd_ack;
      r_ack_s2 <= r_ack_s1;
      r_ack_d  <= r_ack_s2;
      r_clr_s1 <= err_clr;
      r_clr_s2 <= r_clr_s1;
      r_clr_d  <= r_clr_s2;
    end
  end

  assign w_ack_rise = r_ack_s2 & ~r_ack_d;
  assign w_clr_rise = r_clr_s2 & ~r_clr_d;

  // Receiver state, tick divider and shift register.
  rx_state_t                 r_state;
  logic [DW-1:0]             r_div_cnt;
  logic [TW-1:0]             r_tick_cnt;
  logic [IW-1:0]             r_bit_idx;
  logic [BITS_PER_FRAME-1:0] r_shift;
  logic                      w_tick;
  logic                      w_stop_sample;
  logic                      w_push;
  logic                      w_frame_err;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_drop;

  // The divider is held at zero in IDLE so the first tick of a frame lands
  // exactly DIV clocks after the start edge is seen.
  assign w_tick        = (r_state != IDLE) && (r_div_cnt == DW'(DIV - 1));
  assign w_stop_sample = (r_state == STOP) && w_tick && (r_tick_cnt == TW'(OVERSAMPLE - 1));
  // Push is taken straight from the stop sample so the byte is at the FIFO
  // head on the clock after that sample.
  assign w_push        = w_stop_sample && r_rx_s2;
  assign w_frame_err   = w_stop_sample && !r_rx_s2;
  assign w_drop        = w_push && w_full && !w_ack_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      if (r_state == IDLE || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end

      case (r_state)
        IDLE: begin
          r_tick_cnt <= '0;
          r_bit_idx  <= '0;
          if (!r_rx_s2) begin
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == TW'(OVERSAMPLE / 2 - 1)) begin
              r_tick_cnt <= '0;
              r_bit_idx  <= '0;
              // A line that is high again at mid start bit was a glitch.
              r_state    <= r_rx_s2 ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rx_s2, r_shift[BITS_PER_FRAME-1:1]};
              if (r_bit_idx == IW'(BITS_PER_FRAME - 1)) begin
                r_state <= STOP;
              end else begin
                r_bit_idx <= r_bit_idx + IW'(1);
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
              r_tick_cnt <= '0;
              r_state    <= r_rx_s2 ? IDLE : BRK;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        BRK: begin
          // Stay here for the whole low period so a break reports only once.
          if (r_rx_s2) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same clock as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (w_frame_err) begin
        framing_err <= 1'b1;
      end else if (w_clr_rise) begin
        framing_err <= 1'b0;
      end
      if (w_drop) begin
        overrun <= 1'b1;
      end else if (w_clr_rise) begin
        overrun <= 1'b0;
      end
    end
  end

  uart_rx_fifo #(
    .WIDTH (BITS_PER_FRAME),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (r_shift),
    .pop       (w_ack_rise),
    .head      (data_out),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign data_valid = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_byte_port
// Purpose  : Self-checking bench for uart_rx_byte_port. A queue-based model
//            of the receive buffer and error flags is compared against the
//            DUT every clock while the outputs are settled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte_port;

  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 625_000;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLK    = CLK_HZ / BAUD;        // 80 clk per bit
  localparam int FRAME_CLK  = 10 * BIT_CLK;
  localparam int DIV        = 5;                    // round(50e6 / (625e3 * 16))
  // Stop sample edge, counting from the first clk edge after the start bit is
  // driven: 3 edges to reach the receiver, then 8 + 9*16 ticks of DIV clk.
  localparam int STOP_EDGE  = 3 + DIV * (OVERSAMPLE / 2 + 9 * OVERSAMPLE);
  // A level raised at this cycle index turns into an edge at STOP_EDGE.
  localparam int COINCIDE   = STOP_EDGE - 3;

  logic       clk;
  logic       reset_n;
  logic       rxd;
  logic       rd_ack;
  logic       err_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       overrun;

  uart_rx_byte_port #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rxd         (rxd),
    .rd_ack      (rd_ack),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model.
  logic [7:0] q[$];
  logic       m_fe;
  logic       m_ov;
  bit         chk_en;
  int         checks;
  int         errors;
  int         first_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, sampled just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en && reset_n) begin
        check("cmp_data_out", 32'(data_out), 32'((q.size() > 0) ? q[0] : 8'h00));
        check("cmp_data_valid", 32'(data_valid), 32'(q.size() > 0));
        check("cmp_framing_err", 32'(framing_err), 32'(m_fe));
        check("cmp_overrun", 32'(overrun), 32'(m_ov));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives ncyc clocks of an 8N1 frame; ack_at/clr_at raise rd_ack/err_clr at that cycle.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int ack_at,
                             input int clr_at, input int ncyc);
    chk_en      = 1'b0;
    first_valid = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (first_valid < 0 && data_valid) first_valid = c;
      if (c < BIT_CLK)            rxd = 1'b0;
      else if (c < 9 * BIT_CLK)   rxd = d[(c - BIT_CLK) / BIT_CLK];
      else                        rxd = stop;
      if (c == ack_at) rd_ack = 1'b1;
      if (c == clr_at) err_clr = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] d, input int ack_at, input int clr_at);
    drive_frame(d, 1'b1, ack_at, clr_at, FRAME_CLK);
    @(negedge clk);
    rxd = 1'b1; rd_ack = 1'b0; err_clr = 1'b0;
    // Everything requested lands on the stop-sample clock: clear, pop, push.
    if (clr_at >= 0) begin m_fe = 1'b0; m_ov = 1'b0; end
    if (ack_at >= 0 && q.size() > 0) void'(q.pop_front());
    if (q.size() < FIFO_DEPTH) q.push_back(d);
    else m_ov = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic pop_byte();
    @(negedge clk);
    rd_ack = 1'b1; chk_en = 1'b0;
    repeat (4) @(negedge clk);
    if (q.size() > 0) void'(q.pop_front());
    chk_en = 1'b1; rd_ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1; chk_en = 1'b0;
    repeat (4) @(negedge clk);
    m_fe = 1'b0; m_ov = 1'b0;
    chk_en = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Frame with a low stop bit, line kept low for hold clocks, cleared midway.
  task automatic send_break(input logic [7:0] d, input int hold);
    drive_frame(d, 1'b0, -1, -1, FRAME_CLK);
    @(negedge clk);
    m_fe = 1'b1; chk_en = 1'b1;
    repeat (hold / 2) @(negedge clk);
    pulse_clr();
    repeat (hold / 2) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic glitch(input int len);
    repeat (len) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    @(negedge clk);
    rxd = 1'b1;
    idle(60);
  endtask

  int r;

  initial begin
    rxd = 1'b1; rd_ack = 1'b0; err_clr = 1'b0; reset_n = 1'b0;
    chk_en = 1'b0; checks = 0; errors = 0; m_fe = 1'b0; m_ov = 1'b0;
    first_valid = -1;

    check("calc_div_default", 32'(uart_pkg::calc_div(longint'(50_000_000), longint'(9600), longint'(16))), 32'd326);

    repeat (3) @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_data_valid", 32'(data_valid), 32'h0);
    check("reset_framing_err", 32'(framing_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);
    chk_en = 1'b1;

    // 1: one clean frame, latency from the stop-bit mid sample.
    send(8'hA5, -1, -1);
    check("t1_latency_window", 32'(first_valid >= STOP_EDGE - 3 && first_valid <= STOP_EDGE + 3), 32'h1);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_flags", 32'({framing_err, overrun}), 32'h0);
    pop_byte();
    idle(10);

    // 2: short low glitch on the line.
    glitch(30);
    check("t2_no_push", 32'(data_valid), 32'h0);

    // 3: framing error followed by a held break, then a normal frame.
    drive_frame(8'h3C, 1'b0, -1, -1, FRAME_CLK);
    @(negedge clk);
    m_fe = 1'b1; chk_en = 1'b1;
    check("t3_framing_set", 32'(framing_err), 32'h1);
    check("t3_fifo_empty", 32'(data_valid), 32'h0);
    idle(100);
    pulse_clr();
    idle(100);
    rxd = 1'b1;
    idle(20);
    check("t3_single_error", 32'(framing_err), 32'h0);
    send(8'h11, -1, -1);
    check("t3_next_frame", 32'(data_out), 32'h11);
    pop_byte();
    idle(10);

    // 4: five frames into a four-deep buffer.
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), -1, -1);
      idle(10);
    end
    check("t4_overrun", 32'(overrun), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check("t4_readout", 32'(data_out), 32'(i));
      pop_byte();
    end
    check("t4_empty_valid", 32'(data_valid), 32'h0);
    check("t4_empty_data", 32'(data_out), 32'h0);
    pulse_clr();

    // 5: full buffer, pop lands on the same clock as the push of 8'h77.
    for (int i = 0; i < 4; i++) begin
      send(8'h40 + 8'(i), -1, -1);
      idle(10);
    end
    send(8'h77, COINCIDE, -1);
    check("t5_no_overrun", 32'(overrun), 32'h0);
    check("t5_head_after_pop", 32'(data_out), 32'h41);
    repeat (3) pop_byte();
    check("t5_last_entry", 32'(data_out), 32'h77);
    pop_byte();
    check("t5_drained", 32'(data_valid), 32'h0);

    // Overrun set on the same clock as an err_clr edge: the set wins.
    for (int i = 0; i < 4; i++) begin
      send(8'h50 + 8'(i), -1, -1);
      idle(10);
    end
    send(8'hEE, -1, COINCIDE);
    check("set_beats_clear", 32'(overrun), 32'h1);
    repeat (4) pop_byte();
    pulse_clr();

    // 6: reset in the middle of a data bit with two bytes buffered.
    send(8'h21, -1, -1);
    idle(10);
    send(8'h22, -1, -1);
    idle(10);
    drive_frame(8'h99, 1'b1, -1, -1, 300);
    @(negedge clk);
    reset_n = 1'b0; rxd = 1'b1;
    #1;
    check("t6_reset_data_out", 32'(data_out), 32'h0);
    check("t6_reset_flags", 32'({data_valid, framing_err, overrun}), 32'h0);
    q.delete(); m_fe = 1'b0; m_ov = 1'b0;
    idle(5);
    reset_n = 1'b1;
    idle(20);
    chk_en = 1'b1;
    send(8'hC3, -1, -1);
    check("t6_after_reset", 32'(data_out), 32'hC3);
    check("t6_latency_window", 32'(first_valid >= STOP_EDGE - 3 && first_valid <= STOP_EDGE + 3), 32'h1);
    pop_byte();
    idle(10);

    // Randomized traffic against the model.
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0:       glitch(int'($urandom_range(3, 30)));
        1:       send_break(8'($urandom), int'($urandom_range(40, 200)));
        2, 3:    pop_byte();
        4:       pulse_clr();
        default: send(8'($urandom),
                      ($urandom_range(0, 3) == 0) ? COINCIDE : -1,
                      ($urandom_range(0, 4) == 0) ? COINCIDE : -1);
      endcase
      idle(int'($urandom_range(5, 30)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
